// File: rtl/register_file.sv
// Purpose: 2**SEL_W x DATA_W register file with one write port and two independent read ports.
// Latency: 1-cycle write-to-read latency, 0-cycle read latency; REGFILE_BYPASS_EN gives same-cycle write-through.
// Backpressure: none; every non-reset edge writes register[replaceSel], and reads are always valid.
module register_file #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] replaceData,
    input  logic [SEL_W-1:0]  replaceSel,
    input  logic [SEL_W-1:0]  A_sel,
    input  logic [SEL_W-1:0]  B_sel,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B
);

    localparam int DEPTH = 2 ** SEL_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DATA_W-1:0] w_a_stored;
    logic [DATA_W-1:0] w_b_stored;

    // Storage: reset clears every entry and wins over the write; otherwise exactly one entry loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_regs[replaceSel] <= replaceData;
        end
    end

    assign w_a_stored = r_regs[A_sel];
    assign w_b_stored = r_regs[B_sel];

`ifdef REGFILE_BYPASS_EN
    // Read ports with write-through; bypass is held off during reset so the cleared value shows.
    always_comb begin
        A = w_a_stored;
        B = w_b_stored;
        if (!reset && (A_sel == replaceSel)) begin
            A = replaceData;
        end
        if (!reset && (B_sel == replaceSel)) begin
            B = replaceData;
        end
    end
`else
    // Read ports return stored contents only; a write becomes visible from the next edge.
    always_comb begin
        A = w_a_stored;
        B = w_b_stored;
    end
`endif

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic       clk;
    logic       reset;
    logic [7:0] replaceData;
    logic [3:0] replaceSel;
    logic [3:0] A_sel;
    logic [3:0] B_sel;
    logic [7:0] A;
    logic [7:0] B;

    int n_assert;
    int n_fail;

    register_file #(.DATA_W(8), .SEL_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .replaceData (replaceData),
        .replaceSel  (replaceSel),
        .A_sel       (A_sel),
        .B_sel       (B_sel),
        .A           (A),
        .B           (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] rd_exp;
        logic [7:0] wr_exp;
        logic [7:0] sweep_a;
        logic [7:0] sweep_b;
        logic [3:0] idx;
        logic [3:0] idx_b;
        n_assert = 0;
        n_fail   = 0;

        // Reset for one edge, then read two arbitrary selects
        reset = 1'b1; replaceSel = 4'd0; replaceData = 8'h00; A_sel = 4'd0; B_sel = 4'd0;
        tick();
        A_sel = 4'd3; B_sel = 4'd15;
        #1;
        chk("reset_A3", A, 8'h00);
        chk("reset_B15", B, 8'h00);

        // Bypass must be suppressed while reset is high
        replaceSel = 4'd3; replaceData = 8'h99;
        #1;
        chk("reset_nobypass_A3", A, 8'h00);

        // Reset priority over a write to reg2
        replaceSel = 4'd2; replaceData = 8'hFF; A_sel = 4'd2;
        tick();
        chk("rstprio_reg2_cleared", A, 8'h00);
        reset = 1'b0;
        #1;
`ifdef REGFILE_BYPASS_EN
        rd_exp = 8'hFF;
`else
        rd_exp = 8'h00;
`endif
        chk("rstprio_reg2_pre_edge", A, rd_exp);
        tick();
        chk("rstprio_reg2_written", A, 8'hFF);

        // Sequential writes to reg0..reg2
        replaceSel = 4'd0; replaceData = 8'hAA; tick();
        replaceSel = 4'd1; replaceData = 8'hBB; tick();
        replaceSel = 4'd2; replaceData = 8'hCC; tick();
        A_sel = 4'd0; B_sel = 4'd0; #1;
        chk("seq_A0", A, 8'hAA);
        chk("seq_B0", B, 8'hAA);
        A_sel = 4'd1; B_sel = 4'd0; #1;
        chk("seq_A1", A, 8'hBB);
        chk("seq_B0b", B, 8'hAA);
        A_sel = 4'd2; B_sel = 4'd1; #1;
        chk("seq_A2", A, 8'hCC);
        chk("seq_B1", B, 8'hBB);

        // Retention: reg15 untouched while reg14 is rewritten
        replaceSel = 4'd15; replaceData = 8'h5A; tick();
        replaceSel = 4'd14; replaceData = 8'h11; tick();
        B_sel = 4'd14; #1;
        chk("ret_reg14_first", B, 8'h11);
        replaceData = 8'h22;
        tick(); tick(); tick();
        A_sel = 4'd15; B_sel = 4'd14; #1;
        chk("ret_reg15", A, 8'h5A);
        chk("ret_reg14", B, 8'h22);
        A_sel = 4'd0; B_sel = 4'd1; #1;
        chk("ret_reg0", A, 8'hAA);
        chk("ret_reg1", B, 8'hBB);

        // Read during write on reg4; B looks at an unwritten register
        replaceSel = 4'd4; replaceData = 8'h33; tick();
        replaceData = 8'h77; A_sel = 4'd4; B_sel = 4'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        rd_exp = 8'h77;
`else
        rd_exp = 8'h33;
`endif
        chk("rdw_A4_pre_edge", A, rd_exp);
        chk("rdw_B5_independent", B, 8'h00);
        tick();
        chk("rdw_A4_post_edge", A, 8'h77);

        // Same register on both ports, both looking at the write target
        B_sel = 4'd4; replaceData = 8'h78;
        #1;
`ifdef REGFILE_BYPASS_EN
        rd_exp = 8'h78;
`else
        rd_exp = 8'h77;
`endif
        chk("rdw_A4_shared", A, rd_exp);
        chk("rdw_B4_shared", B, rd_exp);
        tick();
        chk("rdw_B4_post_edge", B, 8'h78);

        // Mid-sequence reset discards everything, writes resume right after
        reset = 1'b1; replaceSel = 4'd6; replaceData = 8'h66;
        tick();
        A_sel = 4'd15; B_sel = 4'd4; #1;
        chk("midrst_reg15", A, 8'h00);
        chk("midrst_reg4", B, 8'h00);
        reset = 1'b0;
        tick();
        A_sel = 4'd6; B_sel = 4'd2; #1;
        chk("midrst_reg6_resumed", A, 8'h66);
        chk("midrst_reg2_cleared", B, 8'h00);

        // Sweep: fill every register with a distinct pattern, then read all pairs
        for (int i = 0; i < 16; i++) begin
            idx = i[3:0];
            replaceSel = idx;
            replaceData = {idx, ~idx};
            tick();
        end
        // Parked on reg15 rewriting its own value, so bypass reads agree too
        for (int i = 0; i < 16; i++) begin
            idx   = i[3:0];
            idx_b = 4'd15 - idx;
            A_sel = idx;
            B_sel = idx_b;
            #1;
            sweep_a = {idx, ~idx};
            sweep_b = {idx_b, ~idx_b};
            chk("sweep_A", A, sweep_a);
            chk("sweep_B", B, sweep_b);
        end

        // Final overwrite of reg0 with the all-ones pattern
        replaceSel = 4'd0; replaceData = 8'hFF; A_sel = 4'd1; tick();
        wr_exp = 8'hFF;
        A_sel = 4'd0; #1;
        chk("final_reg0", A, wr_exp);
        A_sel = 4'd1; #1;
        chk("final_reg1_kept", A, 8'h1E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the register and data width in bits.
REQ-002 The block SHALL have parameter SEL_W, default 4, giving the select width; register count is 2**SEL_W (16 by default).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port replaceData, input, DATA_W bits: write data.
REQ-006 The block SHALL have port replaceSel, input, SEL_W bits: write address.
REQ-007 The block SHALL have port A_sel, input, SEL_W bits: read address, port A.
REQ-008 The block SHALL have port B_sel, input, SEL_W bits: read address, port B.
REQ-009 The block SHALL have port A, output, DATA_W bits: read data, port A.
REQ-010 The block SHALL have port B, output, DATA_W bits: read data, port B.

Function
REQ-011 The block SHALL hold 2**SEL_W registers of DATA_W bits each, indexed 0 to 2**SEL_W-1; register 0 is an ordinary writable register.
REQ-012 On every rising clk edge with reset low, register[replaceSel] SHALL load replaceData; there is no write enable, so exactly one register is written each cycle.
REQ-013 Registers not addressed by replaceSel SHALL retain their values.
REQ-014 A SHALL equal register[A_sel] and B SHALL equal register[B_sel] combinationally, with zero-cycle read latency.
REQ-015 Both read ports SHALL be fully independent and SHALL be allowed to select the same register, including the one being written.
REQ-016 Without bypass (see Configuration), a read of the register being written SHALL return the old value until the edge, and the new value from the edge onward, so write-to-read latency is 1 cycle.
REQ-017 Writes SHALL have no wrap or overflow; data is stored verbatim, truncated to DATA_W.
REQ-018 X or Z on replaceSel SHALL NOT be required to be handled; the bench drives known values.

Reset
REQ-019 With reset high at a rising clk edge, all registers SHALL be cleared to 0, and reset SHALL take priority over the write that cycle.
REQ-020 After reset, A and B SHALL read 0 for any select until written.
REQ-021 Reset asserted mid-sequence SHALL discard all prior contents on that edge only, and writes SHALL resume on the first edge with reset low.

Configuration
REQ-022 The block SHALL support macro REGFILE_BYPASS_EN; when defined, if A_sel==replaceSel then A SHALL equal replaceData combinationally (same for B with B_sel), giving same-cycle write-through.
REQ-023 When REGFILE_BYPASS_EN is defined, bypass SHALL be suppressed while reset is high, and the output SHALL then be the stored register value.
REQ-024 When REGFILE_BYPASS_EN is undefined, the read ports SHALL return stored values only, per REQ-016.

Verification
REQ-025 Reset scenario: reset=1 for 1 edge, then A_sel=3, B_sel=15 -> A=0x00, B=0x00.
REQ-026 Sequential write/read scenario: write 0xAA to reg0, 0xBB to reg1, 0xCC to reg2 on successive edges, then A_sel=0/B_sel=0 -> A=B=0xAA; A_sel=1/B_sel=0 -> A=0xBB, B=0xAA; A_sel=2/B_sel=1 -> A=0xCC, B=0xBB.
REQ-027 Retention scenario: write 0x5A to reg15 and 0x11 to reg14, then hold replaceSel=14 with data 0x22 for 3 edges -> reg15 still reads 0x5A and reg14 reads 0x22.
REQ-028 Read-during-write scenario: reg4=0x33, replaceSel=4, replaceData=0x77, A_sel=4 -> before the edge A=0x33 (A=0x77 if REGFILE_BYPASS_EN is defined), and after the edge A=0x77.
REQ-029 Reset priority scenario: reset=1 with replaceSel=2 and replaceData=0xFF at an edge -> reg2 reads 0x00, then reset=0 for 1 edge -> reg2 reads 0xFF.
